// File: rtl/ecc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_seq_pkg
// Description : Shared definitions for the ECC engine sequencer: engine
//               opcodes, sequencer FSM states and the packed command width.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_seq_pkg;

    localparam logic [3:0] OP_MUL  = 4'd0;
    localparam logic [3:0] OP_SQR  = 4'd1;
    localparam logic [3:0] OP_RED  = 4'd2;
    localparam logic [3:0] OP_SWAP = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;

    localparam int OP_W  = 4;
    localparam int LEN_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    // Packed command record: {op, start_addr, write_addr, len}
    function automatic int cmd_width(input int aw);
        return OP_W + 2 * aw + LEN_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_engine_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module      : seq_cmd_fifo
// Description : QDEPTH x WIDTH register FIFO holding pending commands.
//               Ports: clk, rst (async, active-high), push/wdata (write side,
//               ignored when full), pop/rdata (head, show-ahead, ignored when
//               empty), count (current occupancy).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_cmd_fifo #(
    parameter int QDEPTH = 4,
    parameter int WIDTH  = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(QDEPTH):0]  count
);

    localparam int PTR_W = $clog2(QDEPTH);

    logic [WIDTH-1:0] mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W + 1)'(QDEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // QDEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ecc_engine_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ecc_engine_sequencer
// Description : Queues field-operation commands and launches one arithmetic
//               engine at a time, with a registered one-hot grant steering the
//               shared RAM bank ports A-D through an AND-OR mux.
//               Ports: cmd_* (valid/ready command queue), cur_* (operands of
//               the running command), eng_start/eng_sel/eng_done (engine
//               handshake), eng_addr/eng_we/eng_wdata (per-engine bank
//               requests), bank_* (muxed bank ports), busy, irq, err.
//               Optional macro SEQ_TIMEOUT_EN adds a TMO_W-bit RUN watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ecc_engine_sequencer #(
    parameter int DATA   = 256,
    parameter int AW     = 3,
    parameter int NENG   = 5,
    parameter int QDEPTH = 4,
    parameter int TMO_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [3:0]               cmd_op,
    input  logic [AW-1:0]            cmd_start_addr,
    input  logic [AW-1:0]            cmd_write_addr,
    input  logic [9:0]               cmd_len,
    output logic [AW-1:0]            cur_start_addr,
    output logic [AW-1:0]            cur_write_addr,
    output logic [9:0]               cur_len,
    output logic [NENG-1:0]          eng_start,
    output logic [NENG-1:0]          eng_sel,
    input  logic [NENG-1:0]          eng_done,
    input  logic [NENG*4*AW-1:0]     eng_addr,
    input  logic [NENG*2-1:0]        eng_we,
    input  logic [NENG*2*DATA-1:0]   eng_wdata,
    output logic [4*AW-1:0]          bank_addr,
    output logic [1:0]               bank_we,
    output logic [2*DATA-1:0]        bank_wdata,
    output logic                     busy,
    output logic [NENG-1:0]          irq,
    output logic                     err
);

    import ecc_seq_pkg::*;

    localparam int CMD_W = cmd_width(AW);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    seq_state_t        state;
    logic [CMD_W-1:0]  fifo_wdata;
    logic [CMD_W-1:0]  fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              cmd_push;
    logic [3:0]        head_op;
    logic [AW-1:0]     head_start;
    logic [AW-1:0]     head_write;
    logic [9:0]        head_len;
    logic              head_legal;
    logic [NENG-1:0]   head_onehot;
    logic [NENG-1:0]   valid_done;
    logic [NENG-1:0]   stray_done;

    assign cmd_ready  = (fifo_count < CNT_W'(QDEPTH));
    assign cmd_push   = cmd_valid && cmd_ready;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_wdata = {cmd_op, cmd_start_addr, cmd_write_addr, cmd_len};
    assign {head_op, head_start, head_write, head_len} = fifo_rdata;

    // Illegal opcodes are also popped, so a bad command cannot wedge the queue.
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign head_legal = (int'(head_op) < NENG);
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NENG; i++) begin
            head_onehot[i] = (head_op == 4'(i));
        end
    end

    // Only the granted engine's done, and only in RUN, counts; the rest is stray.
    assign valid_done = (state == RUN) ? (eng_done & eng_sel) : '0;
    assign stray_done = eng_done & ~valid_done;

    seq_cmd_fifo #(
        .QDEPTH (QDEPTH),
        .WIDTH  (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count)
    );

`ifdef SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic [TMO_W-1:0] tmo_next;
    assign tmo_next = tmo_cnt + 1'b1;
`else
    logic unused_tmo_w;
    assign unused_tmo_w = (TMO_W > 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            eng_sel        <= '0;
            eng_start      <= '0;
            irq            <= '0;
            err            <= 1'b0;
            cur_start_addr <= '0;
            cur_write_addr <= '0;
            cur_len        <= '0;
`ifdef SEQ_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            eng_start <= '0;
            irq       <= '0;
            err       <= |stray_done;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_legal) begin
                            cur_start_addr <= head_start;
                            cur_write_addr <= head_write;
                            cur_len        <= head_len;
                            eng_sel        <= head_onehot;
                            eng_start      <= head_onehot;
                            state          <= LAUNCH;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LAUNCH: begin
                    state <= RUN;
`ifdef SEQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                RUN: begin
                    if (|valid_done) begin
                        irq   <= valid_done;
                        state <= DRAIN;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tmo_next == '1) begin
                        err   <= 1'b1;
                        state <= DRAIN;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
`endif
                end
                DRAIN: begin
                    eng_sel <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // AND-OR bank mux: with no grant every bank output collapses to zero.
    always_comb begin
        bank_addr  = '0;
        bank_we    = '0;
        bank_wdata = '0;
        for (int i = 0; i < NENG; i++) begin
            bank_addr  = bank_addr  | (eng_addr[i*4*AW +: 4*AW]    & {(4*AW){eng_sel[i]}});
            bank_we    = bank_we    | (eng_we[i*2 +: 2]            & {2{eng_sel[i]}});
            bank_wdata = bank_wdata | (eng_wdata[i*2*DATA +: 2*DATA] & {(2*DATA){eng_sel[i]}});
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecc_engine_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ecc_engine_sequencer
// Description : Self-checking bench for ecc_engine_sequencer: vector table of
//               single commands, directed multi-cycle corner sequences and a
//               randomized command stream checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ecc_engine_sequencer;

    localparam int DATA   = 256;
    localparam int AW     = 3;
    localparam int NENG   = 5;
    localparam int QDEPTH = 4;
    localparam int TMO_W  = 6;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [3:0]             cmd_op = '0;
    logic [AW-1:0]          cmd_start_addr = '0;
    logic [AW-1:0]          cmd_write_addr = '0;
    logic [9:0]             cmd_len = '0;
    logic [AW-1:0]          cur_start_addr;
    logic [AW-1:0]          cur_write_addr;
    logic [9:0]             cur_len;
    logic [NENG-1:0]        eng_start;
    logic [NENG-1:0]        eng_sel;
    logic [NENG-1:0]        eng_done = '0;
    logic [NENG*4*AW-1:0]   eng_addr = '0;
    logic [NENG*2-1:0]      eng_we = '0;
    logic [NENG*2*DATA-1:0] eng_wdata = '0;
    logic [4*AW-1:0]        bank_addr;
    logic [1:0]             bank_we;
    logic [2*DATA-1:0]      bank_wdata;
    logic                   busy;
    logic [NENG-1:0]        irq;
    logic                   err;

    int total = 0;
    int bad   = 0;

    ecc_engine_sequencer #(
        .DATA(DATA), .AW(AW), .NENG(NENG), .QDEPTH(QDEPTH), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_start_addr(cmd_start_addr), .cmd_write_addr(cmd_write_addr), .cmd_len(cmd_len),
        .cur_start_addr(cur_start_addr), .cur_write_addr(cur_write_addr), .cur_len(cur_len),
        .eng_start(eng_start), .eng_sel(eng_sel), .eng_done(eng_done),
        .eng_addr(eng_addr), .eng_we(eng_we), .eng_wdata(eng_wdata),
        .bank_addr(bank_addr), .bank_we(bank_we), .bank_wdata(bank_wdata),
        .busy(busy), .irq(irq), .err(err)
    );

    always #5 clk = ~clk;

    // Fixed per-engine bank requests; every engine drives a distinct pattern.
    function automatic logic [4*AW-1:0] eaddr(input int e);
        logic [4*AW-1:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) r[b*AW +: AW] = AW'((e * 3 + b + 1) % 8);
        return r;
    endfunction

    function automatic logic [1:0] ewe(input int e);
        case (e)
            1, 3:    return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [2*DATA-1:0] ewd(input int e);
        return {{32{8'(e * 16 + 9)}}, {32{8'(e * 16 + 1)}}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at a negedge where eng_start is high, or flags a timeout.
    task automatic wait_start(input int bound);
        int n;
        n = 0;
        while (eng_start == '0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (eng_start == '0) check("wait_start_timeout", 64'd0, 64'd1);
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [AW-1:0] sa,
                            input logic [AW-1:0] wa, input logic [9:0] len);
        cmd_valid = 1'b1; cmd_op = op; cmd_start_addr = sa;
        cmd_write_addr = wa; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [3:0]      op;
        logic [AW-1:0]   sa;
        logic [AW-1:0]   wa;
        logic [9:0]      len;
        int              lat;
        logic            legal;
        logic [NENG-1:0] oh;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input int idx);
        int e;
        e = int'(v.op);
        push_cmd(v.op, v.sa, v.wa, v.len);                 // now in cycle 1
        check($sformatf("v%0d_c1_busy", idx), 64'(busy), 64'd1);
        check($sformatf("v%0d_c1_start", idx), 64'(eng_start), 64'd0);
        @(negedge clk);                                    // cycle 2
        if (!v.legal) begin
            check($sformatf("v%0d_illegal_err", idx), 64'(err), 64'd1);
            check($sformatf("v%0d_illegal_start", idx), 64'(eng_start), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_illegal_err_clear", idx), 64'(err), 64'd0);
            check($sformatf("v%0d_illegal_idle", idx), 64'(busy), 64'd0);
            return;
        end
        check($sformatf("v%0d_start", idx), 64'(eng_start), 64'(v.oh));
        check($sformatf("v%0d_sel", idx), 64'(eng_sel), 64'(v.oh));
        check($sformatf("v%0d_cur_sa", idx), 64'(cur_start_addr), 64'(v.sa));
        check($sformatf("v%0d_cur_wa", idx), 64'(cur_write_addr), 64'(v.wa));
        check($sformatf("v%0d_cur_len", idx), 64'(cur_len), 64'(v.len));
        check($sformatf("v%0d_bank_addr", idx), 64'(bank_addr), 64'(eaddr(e)));
        check($sformatf("v%0d_bank_we", idx), 64'(bank_we), 64'(ewe(e)));
        check($sformatf("v%0d_bank_wdata", idx), 64'(bank_wdata == ewd(e)), 64'd1);
        repeat (v.lat) @(negedge clk);                     // cycle 2+lat, RUN
        check($sformatf("v%0d_irq_before", idx), 64'(irq), 64'd0);
        eng_done = v.oh;
        @(negedge clk);
        eng_done = '0;
        check($sformatf("v%0d_irq", idx), 64'(irq), 64'(v.oh));
        check($sformatf("v%0d_sel_drain", idx), 64'(eng_sel), 64'(v.oh));
        @(negedge clk);
        check($sformatf("v%0d_irq_clear", idx), 64'(irq), 64'd0);
        check($sformatf("v%0d_sel_clear", idx), 64'(eng_sel), 64'd0);
        check($sformatf("v%0d_busy_low", idx), 64'(busy), 64'd0);
        check($sformatf("v%0d_bank_addr0", idx), 64'(bank_addr), 64'd0);
        check($sformatf("v%0d_bank_we0", idx), 64'(bank_we), 64'd0);
        check($sformatf("v%0d_bank_wdata0", idx), 64'(bank_wdata == '0), 64'd1);
    endtask

    // Randomized-phase shared state
    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] sa;
        logic [AW-1:0] wa;
        logic [9:0]    len;
    } cmd_t;

    cmd_t            model_q[$];
    bit              stop = 1'b0;
    int              exp_illegal = 0;
    int              exp_legal = 0;
    int              seen_err = 0;
    int              seen_irq = 0;
    int              seen_start = 0;
    logic [NENG-1:0] last_sel = '0;

    initial begin
        for (int e = 0; e < NENG; e++) begin
            eng_addr[e*4*AW +: 4*AW]      = eaddr(e);
            eng_we[e*2 +: 2]              = ewe(e);
            eng_wdata[e*2*DATA +: 2*DATA] = ewd(e);
        end

        vecs[0] = '{4'd1, 3'd2, 3'd5, 10'd571, 10, 1'b1, 5'b00010};
        vecs[1] = '{4'd4, 3'd7, 3'd0, 10'd1023, 1, 1'b1, 5'b10000};
        vecs[2] = '{4'd0, 3'd0, 3'd7, 10'd0, 3, 1'b1, 5'b00001};
        vecs[3] = '{4'd7, 3'd1, 3'd1, 10'd5, 1, 1'b0, 5'b00000};
        vecs[4] = '{4'd5, 3'd3, 3'd4, 10'd9, 1, 1'b0, 5'b00000};
        vecs[5] = '{4'd2, 3'd3, 3'd3, 10'd233, 2, 1'b1, 5'b00100};
        vecs[6] = '{4'd3, 3'd6, 3'd1, 10'd77, 4, 1'b1, 5'b01000};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_outputs", 64'({eng_start, eng_sel, irq, err, busy}), 64'd0);
        check("rst_cur", 64'({cur_start_addr, cur_write_addr, cur_len}), 64'd0);
        check("rst_bank", 64'({bank_addr, bank_we}), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
            @(negedge clk);
        end

        // Queue full: engine 0 stalls while commands keep coming
        begin
            int  acc;
            bit  rdy;
            acc = 0;
            for (int c = 0; c < 8; c++) begin
                cmd_valid = 1'b1; cmd_op = 4'd0; cmd_start_addr = 3'd1;
                cmd_write_addr = 3'd2; cmd_len = 10'(100 + acc);
                rdy = cmd_ready;
                @(negedge clk);
                if (rdy) acc++;
            end
            cmd_valid = 1'b0;
            check("qfull_accepted", 64'(acc), 64'(QDEPTH + 1));
            check("qfull_ready_low", 64'(cmd_ready), 64'd0);
            check("qfull_busy", 64'(busy), 64'd1);
            for (int k = 0; k < QDEPTH + 1; k++) begin
                if (k > 0) begin
                    wait_start(50);
                    @(negedge clk);
                end
                check($sformatf("qfull_order_%0d", k), 64'(cur_len), 64'(100 + k));
                eng_done = 5'b00001;
                @(negedge clk);
                eng_done = '0;
                check($sformatf("qfull_irq_%0d", k), 64'(irq), 64'd1);
            end
            repeat (2) @(negedge clk);
            check("qfull_drained", 64'(busy), 64'd0);
        end

        // Stray done during RUN, then simultaneous valid+stray, then done while idle
        push_cmd(4'd0, 3'd4, 3'd4, 10'd11);
        wait_start(20);
        @(negedge clk);
        eng_done = 5'b10000;
        @(negedge clk);
        eng_done = '0;
        check("stray_err", 64'(err), 64'd1);
        check("stray_no_irq", 64'(irq), 64'd0);
        check("stray_sel_kept", 64'(eng_sel), 64'd1);
        @(negedge clk);
        check("stray_err_clear", 64'(err), 64'd0);
        check("stray_still_run", 64'(busy), 64'd1);
        eng_done = 5'b10001;
        @(negedge clk);
        eng_done = '0;
        check("both_irq", 64'(irq), 64'd1);
        check("both_err", 64'(err), 64'd1);
        repeat (2) @(negedge clk);
        eng_done = 5'b00100;
        @(negedge clk);
        eng_done = '0;
        check("idle_done_err", 64'(err), 64'd1);
        check("idle_done_irq", 64'(irq), 64'd0);
        @(negedge clk);

        // Asynchronous reset mid-RUN with a second command queued
        push_cmd(4'd3, 3'd1, 3'd2, 10'd50);
        push_cmd(4'd1, 3'd1, 3'd2, 10'd51);
        wait_start(20);
        @(negedge clk);
        check("pre_rst_sel", 64'(eng_sel), 64'b01000);
        #2 rst = 1'b1;
        #1;
        check("async_rst_sel", 64'(eng_sel), 64'd0);
        check("async_rst_ready", 64'(cmd_ready), 64'd1);
        check("async_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_queue_lost", 64'({busy, eng_sel}), 64'd0);

`ifdef SEQ_TIMEOUT_EN
        begin
            int  n;
            bit  got_irq;
            push_cmd(4'd2, 3'd0, 3'd0, 10'd1);
            wait_start(20);
            n = 0;
            got_irq = 1'b0;
            while (!err && n < (1 << TMO_W) + 20) begin
                @(negedge clk);
                n++;
                if (irq != '0) got_irq = 1'b1;
            end
            check("tmo_err", 64'(err), 64'd1);
            check("tmo_latency", 64'(n), 64'(1 << TMO_W));
            check("tmo_no_irq", 64'(got_irq), 64'd0);
            repeat (2) @(negedge clk);
            check("tmo_released", 64'({busy, eng_sel}), 64'd0);
        end
`endif

        // Randomized command stream against a queue model
        fork
            begin : pusher
                bit rdy;
                int guard;
                for (int n = 0; n < 40; n++) begin
                    cmd_op = ($urandom % 4 == 0) ? 4'(5 + $urandom % 11) : 4'($urandom % 5);
                    cmd_start_addr = AW'($urandom);
                    cmd_write_addr = AW'($urandom);
                    cmd_len = 10'($urandom);
                    cmd_valid = 1'b1;
                    guard = 0;
                    do begin
                        rdy = cmd_ready;
                        @(negedge clk);
                        guard++;
                    end while (!rdy && guard < 500);
                    if (rdy) begin
                        if (int'(cmd_op) < NENG) begin
                            model_q.push_back('{cmd_op, cmd_start_addr, cmd_write_addr, cmd_len});
                            exp_legal++;
                        end else begin
                            exp_illegal++;
                        end
                    end else begin
                        check("rand_push_timeout", 64'd0, 64'd1);
                    end
                    cmd_valid = 1'b0;
                    repeat ($urandom % 3) @(negedge clk);
                end
                guard = 0;
                while (busy && guard < 3000) begin
                    @(negedge clk);
                    guard++;
                end
                check("rand_drain", 64'(busy), 64'd0);
                repeat (3) @(negedge clk);
                stop = 1'b1;
            end
            begin : responder
                logic [NENG-1:0] sel;
                while (!stop) begin
                    @(negedge clk);
                    if (eng_start != '0) begin
                        sel = eng_start;
                        @(negedge clk);
                        repeat ($urandom % 5) @(negedge clk);
                        eng_done = sel;
                        @(negedge clk);
                        eng_done = '0;
                    end
                end
            end
            begin : monitor
                cmd_t c;
                while (!stop) begin
                    @(negedge clk);
                    if (err) seen_err++;
                    if (irq != '0) begin
                        seen_irq++;
                        check("rand_irq_engine", 64'(irq), 64'(last_sel));
                    end
                    if (eng_start != '0) begin
                        seen_start++;
                        if (model_q.size() == 0) begin
                            check("rand_unexpected_start", 64'(eng_start), 64'd0);
                        end else begin
                            c = model_q.pop_front();
                            last_sel = NENG'(1) << c.op;
                            check("rand_start_engine", 64'(eng_start), 64'(last_sel));
                            check("rand_operands", 64'({cur_start_addr, cur_write_addr, cur_len}),
                                  64'({c.sa, c.wa, c.len}));
                        end
                    end
                end
            end
        join
        check("rand_start_count", 64'(seen_start), 64'(exp_legal));
        check("rand_irq_count", 64'(seen_irq), 64'(exp_legal));
        check("rand_err_count", 64'(seen_err), 64'(exp_illegal));
        check("rand_model_empty", 64'(model_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
